// File: rtl/ife_block_dispatcher.sv
// rtl/ife_block_dispatcher.sv - captures whole instruction blocks and issues them in order to round-robin cores
module ife_block_dispatcher #(
    parameter int BLOCK_ID_WIDTH = 8,
    parameter int INSTR_WIDTH    = 32,
    parameter int BLOCK_SIZE     = 4,
    parameter int NUM_CORES      = 2,
    localparam int IDX_WIDTH     = (BLOCK_SIZE > 1) ? $clog2(BLOCK_SIZE) : 1,
    localparam int CORE_WIDTH    = (NUM_CORES > 1) ? $clog2(NUM_CORES) : 1
) (
    input  logic                                    clk,
    input  logic                                    rst_n,
    input  logic [BLOCK_ID_WIDTH-1:0]               block_id_in,
    input  logic [BLOCK_SIZE-1:0][INSTR_WIDTH-1:0]  block_in,
    input  logic                                    valid_in,
    output logic                                    ready_in,
    output logic [INSTR_WIDTH-1:0]                  instr_out,
    output logic [BLOCK_ID_WIDTH-1:0]               instr_block_id_out,
    output logic [IDX_WIDTH-1:0]                    instr_idx_out,
    output logic [NUM_CORES-1:0]                    instr_valid_out,
    input  logic [NUM_CORES-1:0]                    core_ready,
    output logic                                    block_done,
    output logic [BLOCK_ID_WIDTH-1:0]               block_done_id,
    output logic [CORE_WIDTH-1:0]                   block_done_core
);

    typedef enum logic {IDLE, ISSUE} state_t;

    state_t                                 state_q, state_d;
    logic [IDX_WIDTH-1:0]                   idx_q, idx_d;
    logic [CORE_WIDTH-1:0]                  rr_q, rr_d;
    logic [CORE_WIDTH-1:0]                  tgt_q, tgt_d;
    logic [BLOCK_ID_WIDTH-1:0]              id_q, id_d;
    logic [BLOCK_SIZE-1:0][INSTR_WIDTH-1:0] blk_q, blk_d;
    logic                                   done_q, done_d;
    logic [BLOCK_ID_WIDTH-1:0]              done_id_q, done_id_d;
    logic [CORE_WIDTH-1:0]                  done_core_q, done_core_d;

    logic hs;
    logic last_hs;
    logic accept;

    assign instr_valid_out = (state_q == ISSUE) ? (NUM_CORES'(1) << tgt_q) : '0;
    // The one-hot valid masks core_ready, so other cores' ready lines never advance the block.
    assign hs      = |(instr_valid_out & core_ready);
    assign last_hs = hs && (idx_q == IDX_WIDTH'(BLOCK_SIZE - 1));
    assign ready_in = rst_n && ((state_q == IDLE) || last_hs);
    assign accept  = valid_in && ready_in;

    assign instr_block_id_out = id_q;
    assign instr_idx_out      = idx_q;
    assign block_done         = done_q;
    assign block_done_id      = done_id_q;
    assign block_done_core    = done_core_q;

    always_comb begin
        instr_out = '0;
        for (int i = 0; i < BLOCK_SIZE; i++) begin
            if (idx_q == IDX_WIDTH'(i)) begin
                instr_out = blk_q[i];
            end
        end
    end

    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        rr_d        = rr_q;
        tgt_d       = tgt_q;
        id_d        = id_q;
        blk_d       = blk_q;
        done_d      = 1'b0;
        done_id_d   = '0;
        done_core_d = '0;
        if (hs && !last_hs) begin
            idx_d = idx_q + 1'b1;
        end
        if (last_hs) begin
            done_d      = 1'b1;
            done_id_d   = id_q;
            done_core_d = tgt_q;
            rr_d        = (rr_q == CORE_WIDTH'(NUM_CORES - 1)) ? '0 : rr_q + 1'b1;
            state_d     = IDLE;
            idx_d       = '0;
        end
        // A block accepted on the final handshake goes to the already-advanced pointer.
        if (accept) begin
            state_d = ISSUE;
            idx_d   = '0;
            tgt_d   = rr_d;
            id_d    = block_id_in;
            blk_d   = block_in;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            idx_q       <= '0;
            rr_q        <= '0;
            tgt_q       <= '0;
            id_q        <= '0;
            blk_q       <= '0;
            done_q      <= 1'b0;
            done_id_q   <= '0;
            done_core_q <= '0;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            rr_q        <= rr_d;
            tgt_q       <= tgt_d;
            id_q        <= id_d;
            blk_q       <= blk_d;
            done_q      <= done_d;
            done_id_q   <= done_id_d;
            done_core_q <= done_core_d;
        end
    end

endmodule
